// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the overflow flag V.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             Co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             V;
`endif

`ifdef SERIAL_ADDER_OVF_EN
    modport master (output start, A, B, Ci, input busy, done, Y, Co, V);
    modport slave  (input start, A, B, Ci, output busy, done, Y, Co, V);
`else
    modport master (output start, A, B, Ci, input busy, done, Y, Co);
    modport slave  (input start, A, B, Ci, output busy, done, Y, Co);
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: Y = A + B + Ci over WIDTH bits, DIGIT bits per clock.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a two's-complement overflow output V.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int unsigned SLICES = WIDTH / DIGIT;
    localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned SW     = DIGIT + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIGIT:0]   slice;
`ifdef SERIAL_ADDER_OVF_EN
    logic             v_q, v_d;
`endif

    // Current DIGIT-bit slice sum including the carry register.
    always_comb begin
        slice = SW'({1'b0, a_q[DIGIT-1:0]}) + SW'({1'b0, b_q[DIGIT-1:0]}) + SW'(carry_q);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        v_d     = v_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.Ci;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Slice sum enters at the MSB end so the low slice ends up at bit 0.
                y_d     = (y_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d = slice[DIGIT];
                co_d    = slice[DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDER_OVF_EN
                // Carry into the slice MSB is a^b^s at that bit; the last slice's value sticks.
                v_d     = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
`endif
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Y    = y_q;
    assign bus.Co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.V    = v_q;
`endif

endmodule
